// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: iCE40 PLL reset, lock qualification and retry sequencer.
// Runs on the PLL reference clock and owns the downstream design reset.
module pll_lock_sequencer #(
    parameter int RESET_CYCLES  = 16,
    parameter int STABLE_CYCLES = 1024,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int HOLD_CYCLES   = 256,
    parameter int MAX_RETRIES   = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             locked_in,
    input  logic             restart,
    output logic             pll_resetb,
    output logic             rst_out,
    output logic             ready,
    output logic             fail,
    output logic [2:0]       state,
    output logic [3:0]       retry_count,
    output logic [CNT_W-1:0] loss_count
);
    typedef enum logic [2:0] {
        S_PLL_RESET = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_HOLD      = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_e;

    localparam int RW = $clog2(RESET_CYCLES + 1);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    localparam logic [RW-1:0] RST_LAST   = RW'(RESET_CYCLES - 1);
    localparam logic [SW-1:0] STB_LAST   = SW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(LOCK_TIMEOUT - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
    localparam logic [3:0]    RETRY_LAST = 4'(MAX_RETRIES - 1);
    localparam logic [3:0]    RETRY_MAX  = 4'(MAX_RETRIES);

    state_e           state_q, state_d;
    logic [1:0]       sync_q;
    logic             locked_s;
    logic [RW-1:0]    rst_cnt_q, rst_cnt_d;
    logic [SW-1:0]    stb_cnt_q, stb_cnt_d;
    logic [TW-1:0]    to_cnt_q, to_cnt_d;
    logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
    logic [3:0]       retry_q, retry_d;
    logic [CNT_W-1:0] loss_q, loss_d, loss_inc;
    logic             pll_resetb_q, rst_out_q, ready_q, fail_q;

    assign locked_s = sync_q[1];
    assign loss_inc = (loss_q == '1) ? loss_q : loss_q + CNT_W'(1);

    // Bring the asynchronous LOCK pin into the reference-clock domain
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], locked_in};
        end
    end

    // Next-state, counter and loss bookkeeping; restart overrides everything
    always_comb begin
        state_d    = state_q;
        rst_cnt_d  = rst_cnt_q;
        stb_cnt_d  = stb_cnt_q;
        to_cnt_d   = to_cnt_q;
        hold_cnt_d = hold_cnt_q;
        retry_d    = retry_q;
        loss_d     = loss_q;
        if (restart) begin
            state_d    = S_PLL_RESET;
            rst_cnt_d  = '0;
            stb_cnt_d  = '0;
            to_cnt_d   = '0;
            hold_cnt_d = '0;
            retry_d    = '0;
        end else begin
            unique case (state_q)
                S_PLL_RESET: begin
                    if (rst_cnt_q == RST_LAST) begin
                        state_d   = S_WAIT_LOCK;
                        rst_cnt_d = '0;
                    end else begin
                        rst_cnt_d = rst_cnt_q + RW'(1);
                    end
                end
                S_WAIT_LOCK: begin
                    stb_cnt_d = locked_s ? stb_cnt_q + SW'(1) : '0;
                    to_cnt_d  = to_cnt_q + TW'(1);
                    if (locked_s && stb_cnt_q == STB_LAST) begin
                        state_d   = S_HOLD;
                        stb_cnt_d = '0;
                        to_cnt_d  = '0;
                    end else if (to_cnt_q == TO_LAST) begin
                        stb_cnt_d = '0;
                        to_cnt_d  = '0;
                        if (retry_q == RETRY_LAST) begin
                            state_d = S_FAIL;
                            retry_d = RETRY_MAX;
                        end else begin
                            state_d = S_PLL_RESET;
                            retry_d = retry_q + 4'd1;
                        end
                    end
                end
                S_HOLD: begin
                    if (!locked_s) begin
                        state_d    = S_PLL_RESET;
                        hold_cnt_d = '0;
                        loss_d     = loss_inc;
                    end else if (hold_cnt_q == HOLD_LAST) begin
                        state_d    = S_RUN;
                        hold_cnt_d = '0;
                        retry_d    = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HW'(1);
                    end
                end
                S_RUN: begin
                    if (!locked_s) begin
                        state_d = S_PLL_RESET;
                        loss_d  = loss_inc;
                    end
                end
                S_FAIL: begin
                    state_d = S_FAIL;
                end
                default: begin
                    state_d = S_PLL_RESET;
                end
            endcase
        end
    end

    // State, counters and status outputs registered together from next state
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state_q      <= S_PLL_RESET;
            rst_cnt_q    <= '0;
            stb_cnt_q    <= '0;
            to_cnt_q     <= '0;
            hold_cnt_q   <= '0;
            retry_q      <= '0;
            loss_q       <= '0;
            pll_resetb_q <= 1'b0;
            rst_out_q    <= 1'b1;
            ready_q      <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            stb_cnt_q    <= stb_cnt_d;
            to_cnt_q     <= to_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            retry_q      <= retry_d;
            loss_q       <= loss_d;
            pll_resetb_q <= (state_d != S_PLL_RESET) && (state_d != S_FAIL);
            rst_out_q    <= (state_d != S_RUN);
            ready_q      <= (state_d == S_RUN);
            fail_q       <= (state_d == S_FAIL);
        end
    end

    assign pll_resetb  = pll_resetb_q;
    assign rst_out     = rst_out_q;
    assign ready       = ready_q;
    assign fail        = fail_q;
    assign state       = state_q;
    assign retry_count = retry_q;
    assign loss_count  = loss_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: directed bench for pll_lock_sequencer.
// Stimulus queues expected status words; a monitor checks them on negedge.
module tb_pll_lock_sequencer;
    logic       clk = 1'b0;
    logic       reset;
    logic       locked_in;
    logic       restart;
    logic       pll_resetb;
    logic       rst_out;
    logic       ready;
    logic       fail;
    logic [2:0] state;
    logic [3:0] retry_count;
    logic [3:0] loss_count;

    typedef struct {
        int          cyc;
        string       tag;
        logic [14:0] w;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pll_lock_sequencer #(
        .RESET_CYCLES (4),
        .STABLE_CYCLES(8),
        .LOCK_TIMEOUT (32),
        .HOLD_CYCLES  (6),
        .MAX_RETRIES  (2),
        .CNT_W        (4)
    ) dut (
        .clock_in   (clk),
        .reset      (reset),
        .locked_in  (locked_in),
        .restart    (restart),
        .pll_resetb (pll_resetb),
        .rst_out    (rst_out),
        .ready      (ready),
        .fail       (fail),
        .state      (state),
        .retry_count(retry_count),
        .loss_count (loss_count)
    );

    // Status word implied by a state: {state, pll_resetb, rst_out, ready, fail, retry, loss}
    function automatic logic [14:0] word(int s, int rc, int lc);
        logic pr;
        logic ro;
        logic rd;
        logic fl;
        pr = !(s == 0 || s == 4);
        ro = (s != 3);
        rd = (s == 3);
        fl = (s == 4);
        return {3'(s), pr, ro, rd, fl, 4'(rc), 4'(lc)};
    endfunction

    task automatic push_exp(int d, string tag, int s, int rc, int lc);
        exp_t e;
        e.cyc = cyc + d;
        e.tag = tag;
        e.w   = word(s, rc, lc);
        sb.push_back(e);
    endtask

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: pop every queued expectation whose cycle has arrived
    always @(negedge clk) begin
        logic [14:0] got;
        got = {state, pll_resetb, rst_out, ready, fail, retry_count, loss_count};
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                n_chk++;
                if (sb[i].cyc != cyc || got !== sb[i].w) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d: got st=%0d pr=%b ro=%b rd=%b fl=%b rc=%0d lc=%0d, want st=%0d pr=%b ro=%b rd=%b fl=%b rc=%0d lc=%0d",
                             sb[i].tag, cyc, got[14:12], got[11], got[10], got[9], got[8],
                             got[7:4], got[3:0], sb[i].w[14:12], sb[i].w[11], sb[i].w[10],
                             sb[i].w[9], sb[i].w[8], sb[i].w[7:4], sb[i].w[3:0]);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        reset     = 1'b1;
        locked_in = 1'b0;
        restart   = 1'b0;

        // Reset values, then nominal lock-up
        step(2);
        push_exp(1, "reset_vals", 0, 0, 0);
        step(1);
        reset = 1'b0;
        push_exp(3, "prst_last", 0, 0, 0);
        push_exp(4, "wait_entry", 1, 0, 0);
        step(4);
        locked_in = 1'b1;
        push_exp(9, "pre_hold", 1, 0, 0);
        push_exp(10, "hold_entry", 2, 0, 0);
        push_exp(15, "hold_last", 2, 0, 0);
        push_exp(16, "ready_latency", 3, 0, 0);
        step(16);

        // Repeated loss in RUN, loss_count saturates at 15
        for (int i = 1; i <= 16; i++) begin
            int lc;
            lc = (i > 15) ? 15 : i;
            locked_in = 1'b0;
            if (i == 1) begin
                push_exp(2, "run_pre_loss", 3, 0, 0);
                push_exp(7, "relock_wait", 1, 0, 1);
                push_exp(15, "relock_hold", 2, 0, 1);
            end
            push_exp(3, "run_loss", 0, 0, lc);
            push_exp(21, "rerun", 3, 0, lc);
            step(3);
            locked_in = 1'b1;
            step(18);
        end

        // One more loss while saturated, then async reset in HOLD
        locked_in = 1'b0;
        push_exp(3, "loss_sat", 0, 0, 15);
        push_exp(16, "hold_pre_rst", 2, 0, 15);
        step(3);
        locked_in = 1'b1;
        step(14);
        push_exp(1, "async_reset", 0, 0, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        locked_in = 1'b0;
        #1;
        n_chk++;
        if (state !== 3'd0) begin
            n_fail++;
            $display("FAIL async_state: got %0d want 0", state);
        end
        n_chk++;
        if (pll_resetb !== 1'b0) begin
            n_fail++;
            $display("FAIL async_pll_resetb: got %b want 0", pll_resetb);
        end
        n_chk++;
        if (rst_out !== 1'b1) begin
            n_fail++;
            $display("FAIL async_rst_out: got %b want 1", rst_out);
        end
        n_chk++;
        if (loss_count !== 4'd0) begin
            n_fail++;
            $display("FAIL async_loss: got %0d want 0", loss_count);
        end
        step(3);

        // Lock timeout: one retry then FAIL at cycle 72
        reset = 1'b0;
        push_exp(4, "to_wait", 1, 0, 0);
        push_exp(35, "to_pre", 1, 0, 0);
        push_exp(36, "retry1", 0, 1, 0);
        push_exp(39, "retry_pulse", 0, 1, 0);
        push_exp(40, "wait2", 1, 1, 0);
        push_exp(71, "pre_fail", 1, 1, 0);
        push_exp(72, "fail", 4, 2, 0);
        push_exp(100, "fail_sticky", 4, 2, 0);
        step(101);

        // Restart out of FAIL, lock glitch in WAIT_LOCK, loss in HOLD
        restart = 1'b1;
        push_exp(1, "restart_fail", 0, 0, 0);
        push_exp(15, "glitch_wait", 1, 0, 0);
        push_exp(20, "glitch_pre_hold", 1, 0, 0);
        push_exp(21, "glitch_hold", 2, 0, 0);
        push_exp(25, "hold_c3", 2, 0, 0);
        push_exp(26, "hold_loss", 0, 0, 1);
        push_exp(44, "rerun2", 3, 0, 1);
        step(1);
        restart = 1'b0;
        step(4);
        locked_in = 1'b1;
        step(5);
        locked_in = 1'b0;
        step(1);
        locked_in = 1'b1;
        step(12);
        locked_in = 1'b0;
        step(3);
        locked_in = 1'b1;
        step(18);

        // Restart coincident with lock drop, then restart inside PLL_RESET
        locked_in = 1'b0;
        push_exp(2, "run_pre_rs", 3, 0, 1);
        push_exp(3, "restart_drop", 0, 0, 1);
        push_exp(9, "rs_recount", 0, 0, 1);
        push_exp(10, "rs_wait", 1, 0, 1);
        push_exp(24, "rerun3", 3, 0, 1);
        step(2);
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        locked_in = 1'b1;
        step(2);
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        step(18);

        step(3);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_chk++;
            n_fail++;
            $display("FAIL %s: expectation for cyc=%0d never checked", e.tag, e.cyc);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
